alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand/result width in bits; legal range 4..64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the operation request is valid.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts a request this cycle.
REQ-006 The block SHALL have port a, input, N, meaning operand A.
REQ-007 The block SHALL have port b, input, N, meaning operand B, or the shift amount for shift operations.
REQ-008 The block SHALL have port ALUControl, input, 3, meaning the opcode.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The block SHALL have port ALUResult, output, N, meaning the registered result.
REQ-012 The block SHALL have port ALUFlags, output, 4, meaning the registered {N,Z,C,V} of ALUResult.

Function
REQ-013 Opcode map SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LSL, 110 LSR, 111 MUL. The low 4 codes match the legacy 2-bit ALU.
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted when in_valid && in_ready; a, b and ALUControl SHALL be captured at that edge, and later input changes SHALL have no effect.
REQ-016 For non-MUL ops, accept in IDLE SHALL go to DONE; out_valid SHALL rise the next cycle (latency 1).
REQ-017 For MUL, accept SHALL go to BUSY. The block SHALL run an iterative shift-add of exactly N cycles, then go to DONE. out_valid SHALL rise N+1 cycles after acceptance.
REQ-018 In DONE, out_valid=1, and ALUResult/ALUFlags SHALL hold stable until out_ready=1. At that edge the state SHALL return to IDLE and out_valid SHALL fall.
REQ-019 No bypass SHALL exist: a new request SHALL NOT be accepted in the same cycle the result is consumed. Throughput is at most one op per 2 cycles.
REQ-020 in_valid in BUSY/DONE SHALL be ignored, with no capture and no state change.
REQ-021 ADD: result = (a+b) mod 2^N. C = carry-out. V = 1 if a and b have the same sign and the result sign differs.
REQ-022 SUB: result = (a-b) mod 2^N. C = 1 if no borrow (a>=b unsigned). V = 1 if a and b have different signs and the result sign differs from a.
REQ-023 AND/OR/XOR: bitwise. C=0, V=0.
REQ-024 LSL/LSR: shamt = b[clog2(N)-1:0]; upper bits of b SHALL be ignored. Zero-fill. C = last bit shifted out. If shamt=0, result=a and C=0. V=0.
REQ-025 MUL: unsigned a*b. result = low N bits. C = 1 if the high N bits of the 2N-bit product are nonzero. V=0.
REQ-026 For all ops, N flag = result[N-1] and Z flag = (result==0).

Reset
REQ-027 While rst_n=0, asynchronously: state=IDLE, out_valid=0, ALUResult=0, ALUFlags=0000, and internal multiplier registers SHALL clear. in_ready SHALL be 1 (IDLE).
REQ-028 Reset asserted during BUSY or DONE SHALL abort the operation with no result emitted. After release, the block SHALL accept a new request on the first edge.

Verification
REQ-029 With N=4, ADD a=5 b=3, out_ready=1: one cycle later out_valid=1, ALUResult=8, ALUFlags=1001; then IDLE, in_ready=1.
REQ-030 With N=4, SUB a=3 b=5 -> ALUResult=E, flags 1000. SUB a=0 b=0 -> ALUResult=0, flags 0110. SUB a=8 b=1 -> ALUResult=7, flags 0011.
REQ-031 With N=4, MUL a=5 b=3 -> out_valid exactly 5 cycles after accept, ALUResult=F, flags 1000. MUL a=7 b=7 -> ALUResult=1, flags 0010. in_valid pulses during BUSY SHALL be ignored.
REQ-032 With N=4, LSL a=1001 b=0001 -> ALUResult=0010, C=1. LSR a=0001 b=0101 (shamt=1) -> ALUResult=0, flags 0110. LSL with shamt=0 -> ALUResult=a, C=0.
REQ-033 Backpressure: hold out_ready=0 for 3 cycles after AND 1100&1010 -> ALUResult=1000 and flags=1000 stable, in_ready=0. After out_ready=1, out_valid falls next edge.
REQ-034 Reset mid-MUL (cycle 2 of BUSY) -> immediately out_valid=0, ALUResult=0, ALUFlags=0. After release, ADD 1+1 completes with ALUResult=2.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: add/sub/logic/shift in one cycle, unsigned multiply by iterative shift-add.
// Latency: 1 cycle for non-MUL ops, N+1 cycles for MUL (counted from the accept cycle).
// Backpressure: result and flags held in DONE until out_ready; in_ready only in IDLE, no bypass.
module alu_mc #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ALUResult,
  output logic [3:0]   ALUFlags
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  state_t state, state_nxt;
  logic   accept;
  logic   mul_fin;

  logic [N-1:0]   res_q;
  flags_t         flags_q;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_nxt;
  logic [CW-1:0]  cnt;

  logic [SW-1:0] shamt;
  logic [N:0]    sum_ext;
  logic [N:0]    diff_ext;
  logic [N:0]    shl_ext;
  logic [N:0]    shr_ext;
  logic [N-1:0]  alu_res;
  logic          alu_c;
  logic          alu_v;

  function automatic flags_t mk_flags(input logic [N-1:0] r, input logic c, input logic v);
    flags_t f;
    f.n = r[N-1];
    f.z = (r == '0);
    f.c = c;
    f.v = v;
    return f;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    mul_fin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = (ALUControl == OP_MUL) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (cnt == LAST) begin
          mul_fin   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle ops are evaluated straight from the request and registered at accept.
  assign shamt    = b[SW-1:0];
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign shl_ext  = {1'b0, a} << shamt;
  assign shr_ext  = {a, 1'b0} >> shamt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        alu_res = sum_ext[N-1:0];
        alu_c   = sum_ext[N];
        alu_v   = (a[N-1] == b[N-1]) && (sum_ext[N-1] != a[N-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[N-1:0];
        alu_c   = ~diff_ext[N];
        alu_v   = (a[N-1] != b[N-1]) && (diff_ext[N-1] != a[N-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_LSL: begin
        alu_res = shl_ext[N-1:0];
        alu_c   = shl_ext[N];
      end
      OP_LSR: begin
        alu_res = shr_ext[N:1];
        alu_c   = shr_ext[0];
      end
      default: alu_res = '0;
    endcase
  end

  // The final shift-add step feeds the result register directly so MUL spends exactly N cycles in BUSY.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      flags_q <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else if (accept) begin
      if (ALUControl == OP_MUL) begin
        mcand  <= {{N{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        res_q   <= alu_res;
        flags_q <= mk_flags(alu_res, alu_c, alu_v);
      end
    end else if (state == BUSY) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (mul_fin) begin
        res_q   <= acc_nxt[N-1:0];
        flags_q <= mk_flags(acc_nxt[N-1:0], |acc_nxt[2*N-1:N], 1'b0);
      end
    end
  end

  assign ALUResult = res_q;
  assign ALUFlags  = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at N=4: stimulus pushes expected results, a negedge monitor pops and checks.
module tb_alu_mc;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] ALUResult;
  logic [3:0]   ALUFlags;

  alu_mc #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, LSL = 3'b101, LSR = 3'b110, MUL = 3'b111;

  typedef struct {
    logic [3:0] res;
    logic [3:0] flg;
    int         lat;
    int         k;
    int         id;
  } sb_t;

  sb_t sb[$];
  sb_t cur;
  bit  in_txn = 1'b0;
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, expected event did not occur", nm);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one request, hold it until the accepting edge, then scramble the inputs.
  task automatic issue(input logic [2:0] op, input logic [3:0] aa, input logic [3:0] bb,
                       input logic [3:0] res, input logic [3:0] flg, input int lat,
                       input int id, input bit push);
    int  t;
    int  k;
    sb_t e;
    t = 0;
    while (!in_ready && t < 50) begin
      tick(1);
      t++;
    end
    if (t >= 50) fail("issue_wait_in_ready");
    in_valid   = 1'b1;
    a          = aa;
    b          = bb;
    ALUControl = op;
    k          = cyc;
    tick(1);
    in_valid   = 1'b0;
    a          = ~aa;
    b          = ~bb;
    ALUControl = ~op;
    if (push) begin
      e.res = res;
      e.flg = flg;
      e.lat = lat;
      e.k   = k;
      e.id  = id;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while ((sb.size() != 0 || in_txn || !in_ready) && t < 100) begin
      tick(1);
      t++;
    end
    if (t >= 100) fail(nm);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_txn = 1'b0;
    end else if (out_valid) begin
      if (!in_txn) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got out_valid=1 result=%0h, expected no output", ALUResult);
        end else begin
          cur    = sb.pop_front();
          in_txn = 1'b1;
          chk($sformatf("v%0d_result", cur.id), ALUResult, cur.res);
          chk($sformatf("v%0d_flags", cur.id), ALUFlags, cur.flg);
          chk($sformatf("v%0d_latency", cur.id), cyc - cur.k, cur.lat);
        end
      end else begin
        chk($sformatf("v%0d_hold_result", cur.id), ALUResult, cur.res);
        chk($sformatf("v%0d_hold_flags", cur.id), ALUFlags, cur.flg);
      end
      if (out_ready) in_txn = 1'b0;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    ALUControl = '0;
    out_ready  = 1'b1;
    tick(2);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", ALUResult, 4'h0);
    chk("reset_flags", ALUFlags, 4'h0);
    chk("reset_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    tick(1);

    issue(ADD, 4'h5, 4'h3, 4'h8, 4'b1001, 1, 1, 1'b1);
    wait_done("v1_done");
    chk("in_ready_after_add", in_ready, 1'b1);
    issue(SUB, 4'h3, 4'h5, 4'hE, 4'b1000, 1, 2, 1'b1);   wait_done("v2_done");
    issue(SUB, 4'h0, 4'h0, 4'h0, 4'b0110, 1, 3, 1'b1);   wait_done("v3_done");
    issue(SUB, 4'h8, 4'h1, 4'h7, 4'b0011, 1, 4, 1'b1);   wait_done("v4_done");
    issue(ADD, 4'hF, 4'h1, 4'h0, 4'b0110, 1, 5, 1'b1);   wait_done("v5_done");
    issue(OR_, 4'hC, 4'h3, 4'hF, 4'b1000, 1, 6, 1'b1);   wait_done("v6_done");
    issue(XOR_, 4'hA, 4'hF, 4'h5, 4'b0000, 1, 7, 1'b1);  wait_done("v7_done");
    issue(LSL, 4'h9, 4'h1, 4'h2, 4'b0010, 1, 8, 1'b1);   wait_done("v8_done");
    issue(LSR, 4'h1, 4'h5, 4'h0, 4'b0110, 1, 9, 1'b1);   wait_done("v9_done");
    issue(LSL, 4'hB, 4'h4, 4'hB, 4'b1000, 1, 10, 1'b1);  wait_done("v10_done");
    issue(LSR, 4'h8, 4'h3, 4'h1, 4'b0000, 1, 11, 1'b1);  wait_done("v11_done");
    issue(MUL, 4'h5, 4'h3, 4'hF, 4'b1000, 5, 12, 1'b1);  wait_done("v12_done");
    issue(MUL, 4'h6, 4'h0, 4'h0, 4'b0100, 5, 13, 1'b1);  wait_done("v13_done");

    // Requests presented while BUSY must be ignored.
    issue(MUL, 4'h7, 4'h7, 4'h1, 4'b0010, 5, 14, 1'b1);
    in_valid   = 1'b1;
    ALUControl = ADD;
    a          = 4'h1;
    b          = 4'h1;
    chk("busy_in_ready", in_ready, 1'b0);
    tick(2);
    in_valid = 1'b0;
    wait_done("v14_done");

    // Backpressure with an ignored request during DONE.
    out_ready = 1'b0;
    issue(AND_, 4'hC, 4'hA, 4'h8, 4'b1000, 1, 15, 1'b1);
    in_valid   = 1'b1;
    ALUControl = ADD;
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      tick(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(1);
    chk("bp_release_out_valid", out_valid, 1'b0);
    chk("bp_release_in_ready", in_ready, 1'b1);
    wait_done("v15_done");

    // Reset in the second BUSY cycle aborts the multiply.
    issue(MUL, 4'h5, 4'h3, 4'h0, 4'h0, 0, 16, 1'b0);
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_result", ALUResult, 4'h0);
    chk("abort_flags", ALUFlags, 4'h0);
    chk("abort_in_ready", in_ready, 1'b1);
    tick(2);
    rst_n = 1'b1;
    issue(ADD, 4'h1, 4'h1, 4'h2, 4'b0000, 1, 17, 1'b1);
    wait_done("v17_done");
    tick(8);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
